// File: rtl/mem_stall_ctrl_if.sv
// MEM-stage handshake between the pipeline and the wait-state sequencer.
// The master drives the MEM-stage instruction flags; the sequencer answers with the stall controls.
interface mem_stall_ctrl_if;
  logic        mvalid;
  logic        mm2reg;
  logic        mwmem;
  logic        stall;
  logic        wb_bubble;
  logic        dmem_we;
  logic [1:0]  state;
  logic [15:0] stall_count;

  modport master (
    output mvalid, mm2reg, mwmem,
    input  stall, wb_bubble, dmem_we, state, stall_count
  );

  modport slave (
    input  mvalid, mm2reg, mwmem,
    output stall, wb_bubble, dmem_we, state, stall_count
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// MEM-stage wait-state sequencer: freezes the front of the pipeline while data memory is busy
// and lets each store commit exactly once, in the RELEASE cycle.
module mem_stall_ctrl #(
  parameter int unsigned LOAD_WAIT  = 2,
  parameter int unsigned STORE_WAIT = 1
) (
  input logic              clk,
  input logic              rst,
  mem_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StRelease = 2'd2} state_e;

  localparam logic [3:0] LoadW  = 4'(LOAD_WAIT);
  localparam logic [3:0] StoreW = 4'(STORE_WAIT);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        held_store_q;
  logic [15:0] stall_count_q;

  logic       access;
  logic       is_store;
  logic [3:0] wait_w;
  logic       stall;
  logic       wb_bubble;
  logic       dmem_we;

  always_comb begin
    access    = bus.mvalid & (bus.mm2reg | bus.mwmem);
    is_store  = bus.mwmem & ~bus.mm2reg;
    wait_w    = bus.mm2reg ? LoadW : StoreW;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    dmem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (wait_w == 4'd0) begin
            dmem_we = is_store;
          end else begin
            stall     = 1'b1;
            wb_bubble = 1'b1;
          end
        end
      end
      StWait: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
      end
      StRelease: dmem_we = held_store_q;
      default: ;
    endcase
    // A reset cycle aborts any access in flight, so no control may leak out of it.
    if (rst) begin
      stall     = 1'b0;
      wb_bubble = 1'b0;
      dmem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      held_store_q  <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      if (stall && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (access && (wait_w != 4'd0)) begin
            cnt_q        <= wait_w - 4'd1;
            held_store_q <= is_store;
            state_q      <= (wait_w >= 4'd2) ? StWait : StRelease;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StRelease;
          end
        end
        StRelease: begin
          held_store_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall       = stall;
  assign bus.wb_bubble   = wb_bubble;
  assign bus.dmem_we     = dmem_we;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: three differently parameterised instances share one stimulus stream
// and are compared each cycle against a cycle-number schedule model of the wait rules.
module tb_mem_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic mv, ml, ms;

  always #5 clk = ~clk;

  mem_stall_ctrl_if ifa ();
  mem_stall_ctrl_if ifb ();
  mem_stall_ctrl_if ifc ();

  assign ifa.mvalid = mv;
  assign ifa.mm2reg = ml;
  assign ifa.mwmem  = ms;
  assign ifb.mvalid = mv;
  assign ifb.mm2reg = ml;
  assign ifb.mwmem  = ms;
  assign ifc.mvalid = mv;
  assign ifc.mm2reg = ml;
  assign ifc.mwmem  = ms;

  mem_stall_ctrl #(.LOAD_WAIT(2),  .STORE_WAIT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_stall_ctrl #(.LOAD_WAIT(2),  .STORE_WAIT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mem_stall_ctrl #(.LOAD_WAIT(15), .STORE_WAIT(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic        act_stall[3];
  logic        act_bub[3];
  logic        act_we[3];
  logic [1:0]  act_state[3];
  logic [15:0] act_cnt[3];

  assign act_stall[0] = ifa.stall;
  assign act_stall[1] = ifb.stall;
  assign act_stall[2] = ifc.stall;
  assign act_bub[0]   = ifa.wb_bubble;
  assign act_bub[1]   = ifb.wb_bubble;
  assign act_bub[2]   = ifc.wb_bubble;
  assign act_we[0]    = ifa.dmem_we;
  assign act_we[1]    = ifb.dmem_we;
  assign act_we[2]    = ifc.dmem_we;
  assign act_state[0] = ifa.state;
  assign act_state[1] = ifb.state;
  assign act_state[2] = ifc.state;
  assign act_cnt[0]   = ifa.stall_count;
  assign act_cnt[1]   = ifb.stall_count;
  assign act_cnt[2]   = ifc.stall_count;

  int lw[3] = '{2, 2, 15};
  int sw[3] = '{1, 3, 0};

  // Model: an access occupies MEM from its detection cycle `start` to `start + w` (RELEASE).
  bit active[3];
  int start[3];
  int w[3];
  bit held[3];
  int exp_cnt[3];
  int cyc;

  int tests;
  int fails;

  task automatic chk(input string name, input int i, input logic [15:0] got,
                     input logic [15:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s inst%0d cyc%0d got %0h want %0h", name, i, cyc, got, want);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic l, input logic s);
    bit acc, stv, e_stall, e_we;
    int wv, off;
    logic [1:0] e_state;
    rst = r;
    mv  = v;
    ml  = l;
    ms  = s;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      acc     = v & (l | s);
      stv     = s & ~l;
      wv      = l ? lw[i] : sw[i];
      e_stall = 1'b0;
      e_we    = 1'b0;
      e_state = 2'd0;
      if (!active[i]) begin
        if (acc) begin
          if (wv == 0) e_we = stv;
          else e_stall = 1'b1;
        end
      end else begin
        off = cyc - start[i];
        if (off < w[i]) begin
          e_stall = 1'b1;
          e_state = 2'd1;
        end else begin
          e_state = 2'd2;
          e_we    = held[i];
        end
      end
      if (r) begin
        e_stall = 1'b0;
        e_we    = 1'b0;
      end
      chk("stall", i, 16'(act_stall[i]), 16'(e_stall));
      chk("wb_bubble", i, 16'(act_bub[i]), 16'(e_stall));
      chk("dmem_we", i, 16'(act_we[i]), 16'(e_we));
      chk("state", i, 16'(act_state[i]), 16'(e_state));
      chk("stall_count", i, act_cnt[i], 16'(exp_cnt[i]));
      if (r) begin
        active[i]  = 1'b0;
        exp_cnt[i] = 0;
      end else begin
        if (e_stall && exp_cnt[i] < 65535) exp_cnt[i]++;
        if (!active[i]) begin
          if (acc && wv > 0) begin
            active[i] = 1'b1;
            start[i]  = cyc;
            w[i]      = wv;
            held[i]   = stv;
          end
        end else if (cyc - start[i] == w[i]) begin
          active[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      active[i]  = 1'b0;
      exp_cnt[i] = 0;
      held[i]    = 1'b0;
    end
    rst = 1'b1;
    mv  = 1'b0;
    ml  = 1'b0;
    ms  = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("idle_state", 0, 16'(ifa.state), 16'd0);
    chk("idle_count", 0, ifa.stall_count, 16'd0);

    // Single load, W = 2 on instance A.
    repeat (3) step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("load_count", 0, ifa.stall_count, 16'd2);
    step(1, 0, 0, 0);

    // Single store, W = 1 on instance A.
    repeat (2) step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    chk("store_count", 0, ifa.stall_count, 16'd1);
    step(1, 0, 0, 0);

    // Load then store back-to-back on instance A.
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    chk("ld_st_count", 0, ifa.stall_count, 16'd3);
    step(1, 0, 0, 0);

    // Store with W = 3 on instance B, reset lands in its WAIT cycle.
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    chk("abort_count", 1, ifb.stall_count, 16'd0);
    chk("abort_state", 1, 16'(ifb.state), 16'd0);

    // W = 0 store on instance C: same-cycle write, then ignored when mvalid = 0.
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    repeat (16) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(63) == 0), logic'($urandom_range(3) != 0),
           logic'($urandom_range(1)), logic'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Wait-state sequencer for the MEM stage of the five-stage pipeline. When the instruction in MEM is a load or store and data memory needs wait cycles, it freezes PC, IF/ID, ID/EXE and EXE/MEM, injects bubbles into MEM/WB, and gates the data-memory write strobe so each store commits exactly once. It sits beside EXE/MEM and MEM/WB and drives their hold/bubble controls.

## Interface
Parameters:
- LOAD_WAIT, 2: stall cycles per load, legal 0..15
- STORE_WAIT, 1: stall cycles per store, legal 0..15

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- mvalid  in  1  MEM stage holds a real instruction (0 = bubble)
- mm2reg  in  1  instruction in MEM is a load
- mwmem  in  1  instruction in MEM is a store
- stall  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM this cycle
- wb_bubble  out  1  MEM/WB captures wwreg=0, wm2reg=0 this cycle
- dmem_we  out  1  data-memory write enable
- state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 RELEASE
- stall_count  out  16  total stall cycles since reset, saturating

## Operation
- Access detected when mvalid & (mm2reg | mwmem). W = LOAD_WAIT if mm2reg, else STORE_WAIT. If mm2reg and mwmem are both 1, treat as load.
- Internal 4-bit counter cnt.
- IDLE:
  - access with W = 0: no stall; dmem_we = mwmem & ~mm2reg; stay IDLE.
  - access with W >= 1: stall = 1, wb_bubble = 1, cnt <= W-1; next state WAIT if W >= 2, else RELEASE.
  - no access: all outputs 0, stay IDLE.
- WAIT: stall = 1, wb_bubble = 1, cnt <= cnt-1; when cnt == 1, next state RELEASE. Inputs are ignored; the held instruction is guaranteed stable.
- RELEASE: stall = 0, wb_bubble = 0; dmem_we = held-store flag (a store latched at detection, excluding the load-wins case); next state IDLE unconditionally. The instruction leaves MEM at the end of this cycle. A new access presented in the following cycle is detected in IDLE, so the released instruction is never re-detected.
- dmem_we is never 1 in IDLE-with-stall or WAIT, so each store writes exactly once.
- stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.
- stall, wb_bubble and dmem_we are combinational from state, cnt, the held-store flag and inputs. state, cnt, the held-store flag and stall_count are registered.

## Timing
- Reset, applied synchronously: state = IDLE, cnt = 0, held-store flag = 0, stall_count = 0. stall, wb_bubble and dmem_we are 0 during and after the reset cycle until a new access arrives.
- Reset during WAIT or RELEASE aborts the access. No dmem_we pulse is issued for an aborted store.
- An access with wait W >= 1 detected at cycle T: stall is high in cycles T..T+W-1, RELEASE occurs at T+W, and the instruction advances at the T+W edge. Total occupancy of MEM is W+1 cycles.
- W = 0: zero-latency pass-through. The pipeline never stalls, and store dmem_we is asserted in the same cycle.
- Back-to-back accesses: the second access is detected in the cycle after RELEASE, with no gap cycle beyond RELEASE.
- mvalid = 0 with mm2reg or mwmem set is ignored, so no stall occurs.

## Test plan
- Reset, then idle for 3 cycles -> state = 0, stall = 0, dmem_we = 0, stall_count = 0.
- LOAD_WAIT = 2: load presented at T -> stall = 1 at T and T+1, state sequence 0,1,2,0, dmem_we = 0 throughout, stall_count = 2.
- STORE_WAIT = 1: store at T -> stall = 1 at T only, RELEASE at T+1 with dmem_we = 1 for exactly one cycle, stall_count = 1.
- Load followed immediately by a store (LOAD_WAIT = 2, STORE_WAIT = 1) -> stall pattern 1,1,0,1,0, a single dmem_we pulse in the second RELEASE, stall_count = 3.
- rst asserted in the WAIT cycle of a store with STORE_WAIT = 3 -> next cycle state = 0, stall = 0, no dmem_we pulse ever, stall_count = 0.
- STORE_WAIT = 0 and a store with mvalid = 1 -> dmem_we = 1 in the same cycle, stall = 0. Repeat with mvalid = 0 -> dmem_we = 0.
